// File: rtl/tok_pkg.sv
// Shared token codes, FSM state encoding and ASCII helpers for the keyword tokenizer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package tok_pkg;

  localparam logic [1:0] TOK_WORD  = 2'd0;
  localparam logic [1:0] TOK_BEGIN = 2'd1;
  localparam logic [1:0] TOK_END   = 2'd2;
  localparam logic [1:0] TOK_EOS   = 2'd3;

  // One state per matched keyword prefix, plus IDLE (between words) and ANY (plain word).
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ANY,
    ST_B,
    ST_BE,
    ST_BEG,
    ST_BEGI,
    ST_BEGIN,
    ST_E,
    ST_EN,
    ST_END
  } state_t;

  function automatic logic is_letter(input logic [7:0] c);
    return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
  endfunction

  function automatic logic [7:0] to_lower(input logic [7:0] c);
    return ((c >= 8'h41) && (c <= 8'h5A)) ? (c | 8'h20) : c;
  endfunction

endpackage

// File: rtl/tok_fifo.sv
// Token FIFO: up to two pushes and one pop per cycle, head read combinationally.
// Latency: a pushed entry is visible at the head the cycle after the push edge.
// Backpressure: none internally; the writer must keep two slots free before pushing.
module tok_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 7
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_a,
  input  logic [W-1:0]               data_a,
  input  logic                       push_b,
  input  logic [W-1:0]               data_b,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic                       not_empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] addr_b;
  logic          do_pop;

  // Entry b lands right behind entry a, or in a's slot when a is not pushed.
  assign addr_b    = wr_ptr + AW'(push_a);
  assign not_empty = (count != '0);
  assign do_pop    = pop && not_empty;
  // Head is forced to zero when empty so stale storage never shows on the outputs.
  assign head      = not_empty ? mem[rd_ptr] : '0;

  // Storage write; contents need no reset because count gates the head.
  always_ff @(posedge clk) begin
    if (push_a) mem[wr_ptr] <= data_a;
    if (push_b) mem[addr_b] <= data_b;
  end

  // Pointers wrap naturally (power-of-two depth); count tracks pushes minus pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_a) + AW'(push_b);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count  <= count + CW'(push_a) + CW'(push_b) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/kw_tokenizer.sv
// Splits an ASCII stream into letter words and emits {code,len} tokens (WORD/BEGIN/END/EOS).
// Latency: token is written at the accepting edge; tok_valid rises one cycle later.
// Backpressure: in_ready drops whenever fewer than two token slots are free.
module kw_tokenizer
  import tok_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LEN_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_char,
  input  logic             in_last,
  output logic             in_ready,
  output logic             tok_valid,
  output logic [1:0]       tok_code,
  output logic [LEN_W-1:0] tok_len,
  input  logic             tok_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = 2 + LEN_W;
  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  state_t           state;
  state_t           cur_state;
  state_t           nxt_state;
  logic [LEN_W-1:0] len_cnt;
  logic [LEN_W-1:0] cur_len;
  logic [LEN_W-1:0] nxt_len;
  logic             accept;
  logic             letter;
  logic             word_done;
  logic [7:0]       lc;
  logic             push_word;
  logic             push_eos;
  logic [1:0]       word_code;
  logic [TW-1:0]    head;
  logic [CW-1:0]    fifo_count;

  // Two free slots cover the worst case of a word token plus EOS in one cycle.
  assign in_ready = (fifo_count <= CW'(DEPTH - 2));
  assign accept   = in_valid && in_ready;
  assign letter   = is_letter(in_char);
  assign lc       = to_lower(in_char);

  // Fold the current character into the word first, then decide whether the word closes.
  always_comb begin
    cur_state = state;
    cur_len   = len_cnt;
    if (letter) begin
      cur_len = (state == ST_IDLE) ? LEN_W'(1) :
                ((len_cnt == LEN_MAX) ? len_cnt : len_cnt + LEN_W'(1));
      case (state)
        ST_IDLE: cur_state = (lc == "b") ? ST_B : ((lc == "e") ? ST_E : ST_ANY);
        ST_B:    cur_state = (lc == "e") ? ST_BE   : ST_ANY;
        ST_BE:   cur_state = (lc == "g") ? ST_BEG  : ST_ANY;
        ST_BEG:  cur_state = (lc == "i") ? ST_BEGI : ST_ANY;
        ST_BEGI: cur_state = (lc == "n") ? ST_BEGIN : ST_ANY;
        ST_E:    cur_state = (lc == "n") ? ST_EN   : ST_ANY;
        ST_EN:   cur_state = (lc == "d") ? ST_END  : ST_ANY;
        default: cur_state = ST_ANY;
      endcase
    end
    word_done = !letter || in_last;
    push_word = accept && word_done && (cur_state != ST_IDLE);
    push_eos  = accept && in_last;
    case (cur_state)
      ST_BEGIN: word_code = TOK_BEGIN;
      ST_END:   word_code = TOK_END;
      default:  word_code = TOK_WORD;
    endcase
    nxt_state = word_done ? ST_IDLE : cur_state;
    nxt_len   = word_done ? '0 : cur_len;
  end

  // Keyword-matching FSM and length counter advance only on accepted characters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      len_cnt <= '0;
    end else if (accept) begin
      state   <= nxt_state;
      len_cnt <= nxt_len;
    end
  end

  tok_fifo #(
    .DEPTH (DEPTH),
    .W     (TW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_a    (push_word),
    .data_a    ({word_code, cur_len}),
    .push_b    (push_eos),
    .data_b    ({TOK_EOS, {LEN_W{1'b0}}}),
    .pop       (tok_valid && tok_ready),
    .head      (head),
    .not_empty (tok_valid),
    .count     (fifo_count)
  );

  assign tok_code = head[TW-1 -: 2];
  assign tok_len  = head[LEN_W-1:0];

endmodule

// File: tb/tb_kw_tokenizer.sv
// Scoreboard bench: a word-level string model predicts tokens, a monitor pops and compares.
// Latency: checks the one-cycle token latency and back-to-back WORD/EOS ordering.
// Backpressure: exercises held tokens, full-FIFO stall of in_ready and random tok_ready.
module tb_kw_tokenizer;

  localparam int DEPTH   = 4;
  localparam int LEN_W   = 4;
  localparam int LEN_MAX = 15;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic [7:0]       in_char = 8'h00;
  logic             in_last = 1'b0;
  logic             in_ready;
  logic             tok_valid;
  logic [1:0]       tok_code;
  logic [LEN_W-1:0] tok_len;
  logic             tok_ready = 1'b1;

  int         checks = 0;
  int         errors = 0;
  logic [5:0] exp_q[$];
  string      word = "";
  bit         rand_ready = 1'b0;
  bit         ready_fixed = 1'b1;

  always #5 clk = ~clk;

  kw_tokenizer #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_char   (in_char),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .tok_valid (tok_valid),
    .tok_code  (tok_code),
    .tok_len   (tok_len),
    .tok_ready (tok_ready)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: accumulate the lower-cased word as a string, classify it when it closes.
  task automatic model_char(input logic [7:0] c, input bit last);
    bit alpha;
    int code;
    int l;
    alpha = ((c >= "A") && (c <= "Z")) || ((c >= "a") && (c <= "z"));
    if (alpha) word = $sformatf("%s%c", word, c | 8'h20);
    if ((!alpha || last) && (word.len() != 0)) begin
      code = (word == "begin") ? 1 : ((word == "end") ? 2 : 0);
      l    = (word.len() > LEN_MAX) ? LEN_MAX : word.len();
      exp_q.push_back({2'(code), 4'(l)});
      word = "";
    end
    if (last) exp_q.push_back({2'd3, 4'd0});
  endtask

  // Present one character at a negedge and hold it until accepted.
  task automatic send(input logic [7:0] c, input bit last);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_char  = c;
    in_last  = last;
    while (!in_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    else model_char(c, last);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_str(input string s, input bit last_on_final);
    for (int i = 0; i < s.len(); i++) send(s[i], last_on_final && (i == s.len() - 1));
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  // Consumer ready: random or fixed, updated at each negedge.
  initial begin
    forever begin
      @(negedge clk);
      tok_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_fixed;
    end
  end

  // Monitor: compare every popped token against the scoreboard head.
  initial begin
    logic [5:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && tok_valid && tok_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tok_unexpected: got code %0d len %0d, required no token", tok_code, tok_len);
        end else begin
          e = exp_q.pop_front();
          chk("tok", int'({tok_code, tok_len}), int'(e));
        end
      end
    end
  end

  initial begin
    #3000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    string tbl;
    int    r;
    tbl = "bBeEgGiInNdDxZ .9-";

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_tok_valid", tok_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_tok_code", tok_code, 0);
    chk("rst_tok_len", tok_len, 0);
    reset = 1'b0;
    @(negedge clk);

    // "begin end " with one-cycle latency after each space.
    send_str("begin", 1'b0);
    chk("lat_no_tok_mid_word", tok_valid, 0);
    send(" ", 1'b0);
    chk("lat_begin_valid", tok_valid, 1);
    chk("lat_begin_tok", int'({tok_code, tok_len}), int'({2'd1, 4'd5}));
    send_str("end", 1'b0);
    send(" ", 1'b0);
    chk("lat_end_valid", tok_valid, 1);
    chk("lat_end_tok", int'({tok_code, tok_len}), int'({2'd2, 4'd3}));
    drain();

    // "BeGiN" with in_last: BEGIN then EOS on consecutive cycles, FIFO empty after.
    send_str("BeGiN", 1'b1);
    chk("last_word_tok", int'({tok_valid, tok_code, tok_len}), int'({1'b1, 2'd1, 4'd5}));
    @(negedge clk);
    chk("last_eos_tok", int'({tok_valid, tok_code, tok_len}), int'({1'b1, 2'd3, 4'd0}));
    @(negedge clk);
    chk("last_empty_valid", tok_valid, 0);
    chk("last_empty_ready", in_ready, 1);
    drain();

    // Separator runs and near-miss keywords under random consumer stalls.
    rand_ready = 1'b1;
    send_str("beginx  en. ", 1'b0);
    drain();
    rand_ready = 1'b0;

    // Full FIFO: third token drops in_ready, 'd' waits for one pop.
    ready_fixed = 1'b0;
    repeat (2) @(negedge clk);
    send_str("a b c ", 1'b0);
    chk("full_in_ready", in_ready, 0);
    chk("full_tok_valid", tok_valid, 1);
    fork
      send_str("d ", 1'b0);
      begin
        repeat (4) @(negedge clk);
        chk("full_held_in_ready", in_ready, 0);
        ready_fixed = 1'b1;
      end
    join
    drain();

    // Length saturation: 20 letters give len 15.
    for (int i = 0; i < 20; i++) send("q", 1'b0);
    send(" ", 1'b0);
    drain();

    // Reset with queued tokens and a partial word.
    ready_fixed = 1'b0;
    repeat (2) @(negedge clk);
    send_str("x y ", 1'b0);
    send_str("beg", 1'b0);
    chk("pre_rst_tok_valid", tok_valid, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_tok_valid", tok_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    exp_q.delete();
    word = "";
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    ready_fixed = 1'b1;
    send_str("end ", 1'b0);
    drain();

    // Random streams mixing keywords, fragments, separators and arbitrary bytes.
    rand_ready = 1'b1;
    for (int n = 0; n < 700; n++) begin
      r = $urandom_range(0, 11);
      case (r)
        0: send_str("begin ", 1'b0);
        1: send_str("End", 1'b0);
        2: send_str("BEGIN", 1'b0);
        3: send($urandom_range(0, 255), 1'b0);
        default: send(tbl[$urandom_range(0, tbl.len() - 1)], ($urandom_range(0, 29) == 0));
      endcase
    end
    send(" ", 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
